// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the boot-time instruction loader.
//   state_e : loader FSM states
//   HDR_W   : width of the word-count header
//   LANES   : bytes per instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int HDR_W = 16;
  localparam int LANES = 4;

endpackage

// File: rtl/imem_loader_pack.sv
// imem_loader_pack: assembles little-endian words from a byte stream.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear of the partial word and lane index
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming byte
//   word_ready  : combinational pulse, byte_in completes a word this cycle
//   word        : completed word, valid while word_ready is high
module imem_loader_pack
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic                 word_ready,
  output logic [8*LANES-1:0]   word
);

  logic [1:0]               idx_q, idx_d;
  logic [8*(LANES-1)-1:0]   lanes_q, lanes_d;

  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clr) begin
      idx_d   = '0;
      lanes_d = '0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      // Shift right so the first byte ends up in the least significant lane.
      lanes_d = {byte_in, lanes_q[8*(LANES-1)-1:8]};
    end
  end

  assign word_ready = byte_valid && !clr && (idx_q == 2'(LANES-1));
  assign word       = {byte_in, lanes_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a byte stream
// (16-bit word count, little-endian payload words, optional checksum byte),
// writes the words into instruction memory port 2, then raises RUN.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require the trailing
// modulo-256 checksum byte (CHECK state and running sum).
// Ports:
//   CLK, RESET          : clock, asynchronous active-high reset
//   START               : synchronous re-arm / abort pulse
//   RX_VALID, RX_DATA   : received byte stream, no backpressure
//   DATA_A/WE/WD        : memory write port (registered)
//   RUN, BUSY, ERROR    : status (registered)
//   WORDS               : words written since reset/START
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR = 30'd0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             RX_VALID,
  input  logic [7:0]       RX_DATA,
  output logic [29:0]      DATA_A,
  output logic             DATA_WE,
  output logic [31:0]      DATA_WD,
  output logic             RUN,
  output logic             BUSY,
  output logic             ERROR,
  output logic [HDR_W-1:0] WORDS
);

  localparam logic [HDR_W:0] MAX_W = (HDR_W+1)'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER = ST_CHECK;
`else
  localparam state_e ST_AFTER = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic [7:0]         nlo_q, nlo_d;
  logic [HDR_W-1:0]   cnt_q, cnt_d;
  logic [HDR_W-1:0]   widx_q, widx_d;
  logic [29:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wd_q, wd_d;
  logic               run_q, run_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               acc;
  logic               pay_valid;
  logic               word_ready;
  logic [31:0]        word;
  logic [HDR_W-1:0]   hdr_n;

  assign acc       = RX_VALID && !START;
  // Once all N words are assembled, further bytes must not reach the packer.
  assign pay_valid = acc && (state_q == ST_PAYLOAD) && (widx_q != cnt_q);
  assign hdr_n     = {RX_DATA, nlo_q};

  imem_loader_pack u_pack (
    .clk        (CLK),
    .rst        (RESET),
    .clr        (START),
    .byte_valid (pay_valid),
    .byte_in    (RX_DATA),
    .word_ready (word_ready),
    .word       (word)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_HDR_LO;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (START) begin
      state_d = ST_HDR_LO;
    end else begin
      case (state_q)
        ST_HDR_LO:  if (acc) state_d = ST_HDR_HI;
        ST_HDR_HI: begin
          if (acc) begin
            if ({1'b0, hdr_n} > MAX_W) state_d = ST_ERR;
            else if (hdr_n == '0)      state_d = ST_AFTER;
            else                       state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (word_ready && (widx_q + 16'd1 == cnt_q)) state_d = ST_CHECK;
`else
          // Leave one edge after the final strobe so RUN never overlaps DATA_WE.
          if (widx_q == cnt_q) state_d = ST_DONE;
`endif
        end
        ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (acc) state_d = (RX_DATA == sum_q) ? ST_DONE : ST_ERR;
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs, registered from the next state
  always_comb begin
    run_d   = (state_d == ST_DONE);
    error_d = (state_d == ST_ERR);
    busy_d  = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
              (state_d == ST_PAYLOAD) || (state_d == ST_CHECK);
  end

  // Datapath
  always_comb begin
    nlo_d  = nlo_q;
    cnt_d  = cnt_q;
    widx_d = widx_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    we_d   = word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d  = sum_q;
`endif
    if (START) begin
      widx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d  = '0;
`endif
    end else begin
      if (acc && state_q == ST_HDR_LO) nlo_d = RX_DATA;
      if (acc && state_q == ST_HDR_HI) cnt_d = hdr_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (pay_valid) sum_d = sum_q + RX_DATA;
`endif
      if (word_ready) begin
        widx_d = widx_q + 16'd1;
        addr_d = BASE_ADDR + 30'(widx_q);
        wd_d   = word;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nlo_q   <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b1;
      error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      nlo_q   <= nlo_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign DATA_A  = addr_q;
  assign DATA_WE = we_q;
  assign DATA_WD = wd_q;
  assign RUN     = run_q;
  assign BUSY    = busy_q;
  assign ERROR   = error_q;
  assign WORDS   = widx_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Expected writes,
// timing and status come from a stream-level model of the load format.
module tb_imem_loader;

  localparam logic [29:0] BASE = 30'd0;
  localparam int          MAXW = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START, RX_VALID;
  logic [7:0]  RX_DATA;
  logic [29:0] DATA_A;
  logic        DATA_WE;
  logic [31:0] DATA_WD;
  logic        RUN, BUSY, ERROR;
  logic [15:0] WORDS;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .DATA_A(DATA_A), .DATA_WE(DATA_WE), .DATA_WD(DATA_WD),
    .RUN(RUN), .BUSY(BUSY), .ERROR(ERROR), .WORDS(WORDS)
  );

  always #5 CLK = ~CLK;

  int checks, errors;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [29:0] a; logic [31:0] d; int ed; } wr_t;
  wr_t wr_q[$];
  int  run_edge, err_edge;

  // Sampled on the falling edge, away from the registered output updates.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DATA_WE === 1'b1) wr_q.push_back('{a: DATA_A, d: DATA_WD, ed: cyc});
      if (RUN === 1'b1 && run_edge < 0) run_edge = cyc;
      if (ERROR === 1'b1 && err_edge < 0) err_edge = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic [7:0] sq[$];
  int         acc_e[$];

  task automatic clear_mon();
    wr_q.delete();
    run_edge = -1;
    err_edge = -1;
  endtask

  // Entered and left on a falling edge.
  task automatic send(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(negedge CLK);
    acc_e.push_back(cyc);
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
  endtask

  task automatic do_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    clear_mon();
  endtask

  task automatic run_stream(input int gmax);
    acc_e.delete();
    foreach (sq[i]) begin
      repeat ($urandom_range(gmax, 0)) @(negedge CLK);
      send(sq[i]);
    end
    repeat (8) @(negedge CLK);
  endtask

  task automatic load_nominal(input logic [7:0] ck);
    sq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sq.push_back(ck);
  endtask

  // Stream-level reference: parse header, slice payload into words, sum bytes.
  task automatic check_stream(input string tag);
    int n, de;
    logic [7:0] s;
    logic [31:0] d;
    bit ok;
    n = int'(sq[0]) + 256 * int'(sq[1]);
    if (n > MAXW) begin
      chk({tag, "_wr_cnt"}, 64'(wr_q.size()), 64'd0);
      chk({tag, "_err_edge"}, 64'(err_edge), 64'(acc_e[1]));
      chk({tag, "_error"}, 64'(ERROR), 64'd1);
      chk({tag, "_run"}, 64'(RUN), 64'd0);
      chk({tag, "_busy"}, 64'(BUSY), 64'd0);
      chk({tag, "_words"}, 64'(WORDS), 64'd0);
      return;
    end
    chk({tag, "_wr_cnt"}, 64'(wr_q.size()), 64'(n));
    s = 8'd0;
    for (int k = 0; k < n; k++) begin
      d = 32'd0;
      for (int j = 0; j < 4; j++) begin
        d = d + (32'(sq[2 + 4*k + j]) << (8*j));
        s = s + sq[2 + 4*k + j];
      end
      if (k < wr_q.size()) begin
        chk({tag, "_wr_a"}, 64'(wr_q[k].a), 64'(30'(BASE + 30'(k))));
        chk({tag, "_wr_d"}, 64'(wr_q[k].d), 64'(d));
        chk({tag, "_wr_edge"}, 64'(wr_q[k].ed), 64'(acc_e[1 + 4*k + 4]));
      end
    end
    if (CK) begin
      ok = (sq.size() > 2 + 4*n) && (sq[2 + 4*n] == s);
      de = acc_e[2 + 4*n];
    end else begin
      ok = 1'b1;
      de = (n > 0) ? acc_e[1 + 4*n] + 1 : acc_e[1];
    end
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_words"}, 64'(WORDS), 64'(n));
    if (ok) begin
      chk({tag, "_run_edge"}, 64'(run_edge), 64'(de));
      chk({tag, "_run"}, 64'(RUN), 64'd1);
      chk({tag, "_error"}, 64'(ERROR), 64'd0);
    end else begin
      chk({tag, "_err_edge"}, 64'(err_edge), 64'(de));
      chk({tag, "_run"}, 64'(RUN), 64'd0);
      chk({tag, "_error"}, 64'(ERROR), 64'd1);
    end
  endtask

  typedef struct {
    logic [7:0] lo, hi;
    logic       e_err, e_run, e_busy;
  } hvec_t;
  hvec_t hv[6];

  initial begin
    int delta0, n;
    logic [7:0] s;

    hv[0] = '{lo: 8'h01, hi: 8'h04, e_err: 1'b1, e_run: 1'b0, e_busy: 1'b0};
    hv[1] = '{lo: 8'h00, hi: 8'h04, e_err: 1'b0, e_run: 1'b0, e_busy: 1'b1};
    hv[2] = '{lo: 8'hFF, hi: 8'hFF, e_err: 1'b1, e_run: 1'b0, e_busy: 1'b0};
    hv[3] = '{lo: 8'h00, hi: 8'h00, e_err: 1'b0, e_run: !CK,  e_busy: CK};
    hv[4] = '{lo: 8'h05, hi: 8'h00, e_err: 1'b0, e_run: 1'b0, e_busy: 1'b1};
    hv[5] = '{lo: 8'h00, hi: 8'h05, e_err: 1'b1, e_run: 1'b0, e_busy: 1'b0};

    checks = 0; errors = 0;
    RESET = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    run_edge = -1; err_edge = -1;
    repeat (3) @(negedge CLK);
    chk("rst_a", 64'(DATA_A), 64'd0);
    chk("rst_we", 64'(DATA_WE), 64'd0);
    chk("rst_wd", 64'(DATA_WD), 64'd0);
    chk("rst_run", 64'(RUN), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd1);
    chk("rst_error", 64'(ERROR), 64'd0);
    chk("rst_words", 64'(WORDS), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Header-only vectors
    for (int i = 0; i < 6; i++) begin
      do_start();
      acc_e.delete();
      send(hv[i].lo);
      send(hv[i].hi);
      repeat (3) @(negedge CLK);
      chk($sformatf("hdr%0d_error", i), 64'(ERROR), 64'(hv[i].e_err));
      chk($sformatf("hdr%0d_run", i), 64'(RUN), 64'(hv[i].e_run));
      chk($sformatf("hdr%0d_busy", i), 64'(BUSY), 64'(hv[i].e_busy));
      chk($sformatf("hdr%0d_nowr", i), 64'(wr_q.size()), 64'd0);
      if (hv[i].e_err) chk($sformatf("hdr%0d_err_edge", i), 64'(err_edge), 64'(acc_e[1]));
    end

    // Nominal, back-to-back
    do_start();
    load_nominal(8'h64);
    run_stream(0);
    check_stream("nom");
    if (wr_q.size() == 2) begin
      chk("nom_d0", 64'(wr_q[0].d), 64'h44332211);
      chk("nom_d1", 64'(wr_q[1].d), 64'h88776655);
      chk("nom_a1", 64'(wr_q[1].a), 64'd1);
    end
    delta0 = run_edge - acc_e[acc_e.size() - (CK ? 1 : 2)];

    // Nominal with random gaps: same RUN timing relative to the last consumed byte
    for (int r = 0; r < 3; r++) begin
      do_start();
      load_nominal(8'h64);
      run_stream(5);
      check_stream("gap");
      chk("gap_run_delta", 64'(run_edge - acc_e[acc_e.size() - (CK ? 1 : 2)]), 64'(delta0));
    end

    // Bad checksum
    do_start();
    load_nominal(8'h65);
    run_stream(0);
    check_stream("badck");

    // Abort a partial word with START; the byte in the START cycle is dropped
    do_start();
    acc_e.delete();
    send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    START = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'h02;
    @(negedge CLK);
    START = 1'b0; RX_VALID = 1'b0;
    chk("abort_words", 64'(WORDS), 64'd0);
    chk("abort_nowr", 64'(wr_q.size()), 64'd0);
    clear_mon();
    load_nominal(8'h64);
    run_stream(0);
    check_stream("abort");

    // Asynchronous reset in the middle of a payload
    do_start();
    acc_e.delete();
    send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    send(8'h33); send(8'h44); send(8'h55);
    chk("pre_rst_words", 64'(WORDS), 64'd1);
    chk("pre_rst_wd", 64'(DATA_WD), 64'h44332211);
    #2 RESET = 1'b1;
    #1;
    chk("arst_a", 64'(DATA_A), 64'd0);
    chk("arst_we", 64'(DATA_WE), 64'd0);
    chk("arst_wd", 64'(DATA_WD), 64'd0);
    chk("arst_run", 64'(RUN), 64'd0);
    chk("arst_busy", 64'(BUSY), 64'd1);
    chk("arst_error", 64'(ERROR), 64'd0);
    chk("arst_words", 64'(WORDS), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    clear_mon();
    load_nominal(8'h64);
    run_stream(0);
    check_stream("post_rst");

    // Random streams
    for (int r = 0; r < 25; r++) begin
      do_start();
      sq.delete();
      if ($urandom_range(7, 0) == 0) begin
        n = MAXW + 1 + int'($urandom_range(3000, 0));
        sq.push_back(8'(n)); sq.push_back(8'(n >> 8));
        sq.push_back(8'($urandom)); sq.push_back(8'($urandom));
      end else begin
        n = int'($urandom_range(5, 0));
        sq.push_back(8'(n)); sq.push_back(8'h00);
        s = 8'd0;
        for (int k = 0; k < 4*n; k++) begin
          sq.push_back(8'($urandom));
          s = s + sq[sq.size() - 1];
        end
        sq.push_back(($urandom_range(3, 0) == 0) ? s + 8'd1 : s);
        sq.push_back(8'($urandom));
      end
      run_stream(3);
      check_stream($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader placed upstream of the CPU and instruction memory. Consumes a byte stream from the serial receiver and assembles little-endian 32-bit words. Writes those words into the instruction memory's second port (DATA_A / DATA_WE / DATA_WD), then releases the CPU by driving RUN. While the loader is not finished, RUN stays low and the CPU does not execute.

## Interface
- BASE_ADDR, 30'd0, word address of the first payload word
- MAX_WORDS, 1024, largest accepted word count; must be ≤ 65535
- CLK  in  1  system clock; all state and outputs registered on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  synchronous re-arm pulse; aborts any load and returns to header reception
- RX_VALID  in  1  RX_DATA carries a byte this cycle; no backpressure, loader always accepts
- RX_DATA  in  8  received byte
- DATA_A  out  30  instruction memory port-2 word address
- DATA_WE  out  1  one-cycle write strobe
- DATA_WD  out  32  write data
- RUN  out  1  CPU run enable; high only in DONE
- BUSY  out  1  high in HDR_LO, HDR_HI, PAYLOAD, CHECK
- ERROR  out  1  high in ERR
- WORDS  out  16  count of words written since last reset/START

## Operation
- Stream format:
  - 2-byte word count N, low byte first.
  - N×4 payload bytes; byte k of a word lands in bits [8k+7:8k].
  - One checksum byte (only when checksum is compiled in). The checksum is the 8-bit modulo-256 sum of all payload bytes.
- States: HDR_LO → HDR_HI → PAYLOAD → CHECK → DONE; ERR is the error state.
- Transitions:
  - HDR_LO: accept byte as N[7:0] → HDR_HI.
  - HDR_HI: accept byte as N[15:8].
    - N > MAX_WORDS → ERR.
    - N = 0 → CHECK (checksum build) or DONE.
    - Otherwise → PAYLOAD.
  - PAYLOAD: a 2-bit byte index counts accepted bytes. On the 4th byte, schedule a write and increment the word index.
    - After the last byte of word N-1 → CHECK or DONE.
  - CHECK: accept one byte. Equal to running sum → DONE; otherwise → ERR.
  - DONE, ERR: RX_VALID is ignored; remain until START or RESET.
- Write address is BASE_ADDR + word index, in 30-bit arithmetic that wraps modulo 2^30.
- The running sum is 8 bits wide and wraps. It is cleared on reset and on START.
- START priority:
  - START overrides RX_VALID in the same cycle; that byte is discarded.
  - START clears the index, sum and WORDS, and drops RUN and ERROR. State → HDR_LO.
  - A write already visible on DATA_WE in the START cycle completes. No new write is issued for a partially assembled word.
- Bytes arriving without RX_VALID are never sampled.

## Timing
- Reset values: DATA_A=0, DATA_WE=0, DATA_WD=0, RUN=0, BUSY=1, ERROR=0, WORDS=0, state HDR_LO.
- Reset is asynchronous: asserting RESET mid-load forces all of the above immediately.
- Write latency:
  - If the 4th byte of a word is accepted at edge t, DATA_WE=1 with a stable DATA_A/DATA_WD for the cycle following t.
  - DATA_WE is high for exactly one cycle.
  - WORDS increments at the same edge that raises DATA_WE.
- Throughput: RX_VALID may be high every cycle; one word is written every 4 cycles with no stall. Arbitrary gaps are allowed.
- RUN timing:
  - RUN rises at the edge that enters DONE.
  - With N>0, the final DATA_WE cycle always precedes the first RUN-high cycle.
  - In a no-checksum build, DONE is entered one edge after the final write strobe.
- ERR from an oversized header is entered at the edge accepting the second header byte. No write is ever issued in that case.
- All outputs are registered and hold stable for the full CLK period, so the memory samples them on its offset clock.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The CHECK state exists and the trailing checksum byte is required.
  - A mismatch leads to ERR.
- Undefined:
  - No CHECK state and no sum register.
  - The last payload word, or N=0, leads to DONE.
  - ERR is reachable only by an oversized N.

## Structure
- Shared package imem_loader_pkg contains:
  - the state enum (HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERR);
  - the header length width constant (16);
  - the byte-lane constant (4).
- One sub-module, imem_loader_pack: a byte-to-word shift/lane register with a 2-bit index and a word_ready pulse. The FSM, address counter and checksum stay in the top level.

## Test plan
- Nominal load, checksum build, BASE_ADDR=0:
  - Stimulus: 02 00 11 22 33 44 55 66 77 88 64.
  - Expected: writes A=0 WD=0x44332211, then A=1 WD=0x88776655; RUN=1, WORDS=2, ERROR=0.
- Same stream with last byte 65 → both writes occur, then ERROR=1, RUN=0, BUSY=0.
- MAX_WORDS=1024, header 01 04 (N=1025) → ERROR=1 at the edge after the second byte; DATA_WE never asserts.
- Abort:
  - Stimulus: START after 02 00 11 22, then the full nominal stream.
  - Expected: no write for the partial word; first write at A=BASE_ADDR; WORDS=2.
- Streaming: nominal stream back-to-back every cycle, then repeated with random 0–5 cycle gaps → identical writes and RUN timing relative to the last byte.
- Reset mid-payload: RESET asserted between clock edges → outputs go to reset values without waiting for a clock edge. A fresh nominal stream then loads correctly.
